// File: rtl/alu_mdu_seq_if.sv
// alu_mdu_seq_if - request/response bundle for the alu_mdu_seq execution unit.
// The slave modport is the unit side. The master modport is the decode/writeback side.
interface alu_mdu_seq_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [4:0]       op_i;
  logic             mdu_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_o;
  logic             flag_o;
  logic             busy_o;

  modport slave (
    input  valid_i, a_i, b_i, op_i, mdu_i, ready_i,
    output ready_o, valid_o, result_o, flag_o, busy_o
  );

  modport master (
    output valid_i, a_i, b_i, op_i, mdu_i, ready_i,
    input  ready_o, valid_o, result_o, flag_o, busy_o
  );
endinterface

// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq - handshaked RV32I ALU/compare unit with the RV32M multiply/divide ops.
// ALU ops take a single cycle. Multiply and divide iterate one bit per cycle over WIDTH cycles.
// Optional macro ALU_MDU_FAST_MUL_EN adds a single-cycle combinational multiplier for
// MUL/MULH/MULHSU/MULHU. Divides always stay iterative.
module alu_mdu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic          clk_i,
  input logic          rst_ni,
  alu_mdu_seq_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b10000;
  localparam logic [4:0] OP_SLL  = 5'b00001;
  localparam logic [4:0] OP_SLTS = 5'b00010;
  localparam logic [4:0] OP_SLTU = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SRL  = 5'b00101;
  localparam logic [4:0] OP_SRA  = 5'b01101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_AND  = 5'b00111;
  localparam logic [4:0] OP_EQ   = 5'b11000;
  localparam logic [4:0] OP_NE   = 5'b11001;
  localparam logic [4:0] OP_LTS  = 5'b11100;
  localparam logic [4:0] OP_GES  = 5'b11101;
  localparam logic [4:0] OP_LTU  = 5'b11110;
  localparam logic [4:0] OP_GEU  = 5'b11111;

  localparam logic [2:0] M_MUL    = 3'b000;
  localparam logic [2:0] M_MULH   = 3'b001;
  localparam logic [2:0] M_MULHSU = 3'b010;
  localparam logic [2:0] M_MULHU  = 3'b011;
  localparam logic [2:0] M_DIV    = 3'b100;
  localparam logic [2:0] M_DIVU   = 3'b101;
  localparam logic [2:0] M_REM    = 3'b110;
  localparam logic [2:0] M_REMU   = 3'b111;

  // Control and output registers
  state_e           state_q, state_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             flag_q, flag_d;

  // Iterative datapath: {hi, lo} is the product/shift pair for multiply and
  // {remainder, dividend-shifting-into-quotient} for divide.
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [2:0]       fn_q, fn_d;
  logic             qneg_q, qneg_d;   // negate product / quotient at the end
  logic             rneg_q, rneg_d;   // negate remainder at the end
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude

  logic             accept;
  assign accept = bus.valid_i && ready_q;

  // Single-cycle ALU and compare results from the live operands
  logic [SHW-1:0]   shamt;
  logic             lts, ltu, eq;
  logic [WIDTH-1:0] alu_res;
  logic             alu_flag;
  assign shamt = bus.b_i[SHW-1:0];

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    alu_res  = '0;
    alu_flag = 1'b0;
    lts      = $signed(bus.a_i) < $signed(bus.b_i);
    ltu      = bus.a_i < bus.b_i;
    eq       = bus.a_i == bus.b_i;
    case (bus.op_i)
      OP_ADD:  alu_res = bus.a_i + bus.b_i;
      OP_SUB:  alu_res = bus.a_i - bus.b_i;
      OP_SLL:  alu_res = bus.a_i << shamt;
      OP_SLTS: alu_res = {{(WIDTH-1){1'b0}}, lts};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ltu};
      OP_XOR:  alu_res = bus.a_i ^ bus.b_i;
      OP_SRL:  alu_res = bus.a_i >> shamt;
      OP_SRA:  alu_res = $signed(bus.a_i) >>> shamt;
      OP_OR:   alu_res = bus.a_i | bus.b_i;
      OP_AND:  alu_res = bus.a_i & bus.b_i;
      OP_EQ:   alu_flag = eq;
      OP_NE:   alu_flag = !eq;
      OP_LTS:  alu_flag = lts;
      OP_GES:  alu_flag = !lts;
      OP_LTU:  alu_flag = ltu;
      OP_GEU:  alu_flag = !ltu;
      default: ;
    endcase
  end

  // Operand signs and magnitudes for the M-extension op being accepted
  logic             a_sgn, b_sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (bus.op_i[2:0])
      M_MULH, M_DIV, M_REM: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      M_MULHSU:             a_sgn = 1'b1;
      default: ;
    endcase
    a_neg = a_sgn & bus.a_i[WIDTH-1];
    b_neg = b_sgn & bus.b_i[WIDTH-1];
    a_mag = a_neg ? -bus.a_i : bus.a_i;
    b_mag = b_neg ? -bus.b_i : bus.b_i;
  end

`ifdef ALU_MDU_FAST_MUL_EN
  // Single-cycle multiply: sign-extend to 2*WIDTH; the low 2*WIDTH bits of the
  // product are correct for every signedness combination.
  logic [2*WIDTH-1:0] fast_a, fast_b, fast_prod;
  always_comb begin
    fast_a    = {{WIDTH{a_neg}}, bus.a_i};
    fast_b    = {{WIDTH{b_neg}}, bus.b_i};
    fast_prod = fast_a * fast_b;
  end
`endif

  // One multiply (shift-add) or divide (restoring) iteration plus the final sign fix-up
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [WIDTH-1:0]   hi_nx, lo_nx, quo_fix, rem_fix, mdu_res;
  logic [2*WIDTH-1:0] prod_fix;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, opnd_q};
    if (fn_q[2]) begin
      if (!div_trial[WIDTH]) begin
        hi_nx = div_trial[WIDTH-1:0];
        lo_nx = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_nx = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        lo_nx = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nx = mul_sum[WIDTH:1];
      lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
    prod_fix = qneg_q ? -{hi_nx, lo_nx} : {hi_nx, lo_nx};
    quo_fix  = qneg_q ? -lo_nx : lo_nx;
    rem_fix  = rneg_q ? -hi_nx : hi_nx;
    case (fn_q)
      M_MUL:                      mdu_res = prod_fix[WIDTH-1:0];
      M_MULH, M_MULHSU, M_MULHU:  mdu_res = prod_fix[2*WIDTH-1:WIDTH];
      M_DIV, M_DIVU:              mdu_res = quo_fix;
      default:                    mdu_res = rem_fix;
    endcase
  end

  // Next-state and registered-output logic for the IDLE/BUSY/DONE handshake
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flag_d   = flag_q;
    cnt_d    = cnt_q;
    fn_d     = fn_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!bus.mdu_i) begin
            result_d = alu_res;
            flag_d   = alu_flag;
            state_d  = S_DONE;
          end
`ifdef ALU_MDU_FAST_MUL_EN
          else if (!bus.op_i[2]) begin
            result_d = (bus.op_i[1:0] == 2'b00) ? fast_prod[WIDTH-1:0]
                                                : fast_prod[2*WIDTH-1:WIDTH];
            flag_d   = 1'b0;
            state_d  = S_DONE;
          end
`endif
          else begin
            fn_d    = bus.op_i[2:0];
            cnt_d   = '0;
            flag_d  = 1'b0;
            hi_d    = '0;
            state_d = S_BUSY;
            if (bus.op_i[2]) begin
              // Divide by zero leaves an all-ones quotient and the dividend as
              // remainder; clearing the quotient sign keeps the all-ones pattern.
              lo_d   = a_mag;
              opnd_d = b_mag;
              qneg_d = (bus.b_i == '0) ? 1'b0 : (a_neg ^ b_neg);
              rneg_d = a_neg;
            end else begin
              lo_d   = b_mag;
              opnd_d = a_mag;
              qneg_d = a_neg ^ b_neg;
              rneg_d = 1'b0;
            end
          end
        end
      end
      S_BUSY: begin
        hi_d  = hi_nx;
        lo_d  = lo_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH-1)) begin
          result_d = mdu_res;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_DONE);
    busy_d  = (state_d == S_BUSY);
  end

  // State, output and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the datapath registers are plain flops, not a memory, so clearing them
      // on reset is cheap and guarantees an aborted operation leaves nothing behind.
      state_q  <= S_IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      flag_q   <= 1'b0;
      cnt_q    <= '0;
      fn_q     <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments here, blocking only in always_comb, so every
      // flop samples the pre-edge values regardless of statement order.
      state_q  <= state_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      cnt_q    <= cnt_d;
      fn_q     <= fn_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
    end
  end

  assign bus.ready_o  = ready_q;
  assign bus.valid_o  = valid_q;
  assign bus.busy_o   = busy_q;
  assign bus.result_o = result_q;
  assign bus.flag_o   = flag_q;

endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
- Parametrised, handshaked successor to the lab ALU: the full RV32I ALU/compare op set at WIDTH bits, plus the RV32M multiply/divide ops.
- ALU ops complete in one cycle. Multiply and divide run iteratively over WIDTH cycles.
- Sits between decode and writeback/branch logic in the multi-cycle core, using a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8, power of 2).
- SHW, $clog2(WIDTH), shift-amount bits taken from b_i[SHW-1:0].

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous reset, active-low.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept a request.
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B.
- op_i  in  5  ALU opcode; when mdu_i=1, op_i[2:0] is the M-ext funct3.
- mdu_i  in  1  selects multiply/divide op class.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- result_o  out  WIDTH  registered result.
- flag_o  out  1  registered compare flag.
- busy_o  out  1  iterative op in progress.

Behaviour:
- Reset (rst_ni=0, async): state=IDLE; ready_o=1 after release; valid_o=0, result_o=0, flag_o=0, busy_o=0. All internal accumulators cleared.
- Reset asserted mid-operation aborts it. No result is produced after release.
- FSM states:
  - IDLE: ready_o=1.
  - BUSY: ready_o=0, busy_o=1.
  - DONE: valid_o=1, ready_o=0.
- Accept: valid_i&&ready_o on a rising edge. Operands and op are latched; later input changes are ignored.
- ALU op (mdu_i=0): IDLE->DONE at the accepting edge, so valid_o is high one cycle after acceptance.
- ALU op codes:
  - 00000 ADD, 10000 SUB, 00001 SLL, 00010 SLTS, 00011 SLTU.
  - 00100 XOR, 00101 SRL, 01101 SRA, 00110 OR, 00111 AND.
  - 11000 EQ, 11001 NE, 11100 LTS, 11101 GES, 11110 LTU, 11111 GEU.
- Result ops drive flag_o=0. Compare ops (11xxx) drive result_o=0.
- Undefined ALU codes: result_o=0, flag_o=0, still handshaked normally.
- ADD/SUB wrap modulo 2^WIDTH. Shifts use b_i[SHW-1:0] only.
- MDU op (mdu_i=1) funct3 codes:
  - 000 MUL (low WIDTH bits), 001 MULH (signed x signed, high half), 010 MULHSU (signed A x unsigned B, high half), 011 MULHU (high half).
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- MDU op flow: IDLE->BUSY for exactly WIDTH cycles, then BUSY->DONE. valid_o rises WIDTH+1 cycles after acceptance.
- Multiply: operands converted to magnitudes, radix-2 shift-add over 2*WIDTH-bit product, sign fixed up at the end.
- Divide: operands converted to magnitudes, restoring division, one quotient bit per cycle. Quotient sign = a^b sign; remainder sign = dividend sign.
- Divide by zero (detected at accept; still takes WIDTH cycles):
  - DIV/DIVU quotient = all ones.
  - REM/REMU remainder = a.
- Signed overflow (a = most negative, b = -1):
  - DIV = most negative.
  - REM = 0.
- flag_o=0 for all MDU ops.
- DONE->IDLE on valid_o&&ready_i. While ready_i=0, result_o/flag_o/valid_o are held stable, with no bound on duration.
- ready_o is low in DONE, so there is no back-to-back acceptance. The next accept occurs at the earliest one cycle after the consuming edge.
- valid_i while ready_o=0 is ignored and not queued.

Optional Feature:
- Macro: ALU_MDU_FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU use a single-cycle combinational 2*WIDTH multiplier. They go IDLE->DONE like ALU ops, with 1-cycle latency and busy_o never set. Divides are unchanged.
- Undefined: the iterative multiplier with WIDTH-cycle latency is used, as above.

Test Plan:
- Reset mid-op: start DIVU, pull rst_ni low at BUSY cycle 5 -> outputs 0 asynchronously, IDLE after release, no valid_o.
- ALU op: ADD 0xFFFFFFFF+1 -> result_o=0 one cycle after accept. SRA 0x80000000 by b=0x24 (shamt 4) -> 0xF8000000. LTS -5 vs 3 -> flag_o=1, result_o=0.
- Multiply (macro undefined): MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000 and MULHU -> 0xFFFFFFFE, valid_o 33 cycles after accept, busy_o high 32 cycles. MUL 7 x -3 -> 0xFFFFFFEB.
- Divide: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF. DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100. DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0.
- Backpressure: hold ready_i=0 for 10 cycles in DONE -> result stable, ready_o=0, valid_i pulses ignored. Raise ready_i -> next cycle IDLE, next request accepted.
- Macro defined: MUL 12345 x 6789 -> 0x04FED79D one cycle after accept, busy_o never asserted.
